jt053247_draw: RTL

Sprite tile drawer. It consumes one 16-pixel-wide tile row per dr_start from the 053246 table scanner. It fetches two 32-bit ROM words, applies flips and horizontal zoom, and writes non-transparent pixels into the external object line buffer. It sits directly downstream of the scanner and returns dr_busy to pace it.

---
 rtl/jt053247_pkg.sv | 23 ++
 rtl/jt053247_zstep.sv | 36 +++
 rtl/jt053247_draw.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/jt053247_pkg.sv
// Shared constants and types for the 053247 sprite tile drawer.
package jt053247_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH0 = 2'd1;
    localparam logic [1:0] ST_FETCH1 = 2'd2;
    localparam logic [1:0] ST_DRAW   = 2'd3;

    localparam logic [9:0] ZOOM_ONE = 10'h040;
    localparam logic [3:0] TRANSP   = 4'h0;
    localparam logic [8:0] CLIP_LO  = 9'h020;
    localparam logic [8:0] CLIP_HI  = 9'h19F;

    // Tile parameters that are still needed after both ROM words are fetched.
    typedef struct packed {
        logic [9:0] attr;
        logic       hflip;
        logic [8:0] hpos;
        logic [9:0] hzoom;
        logic       keep;
    } tile_t;

endpackage

// File: rtl/jt053247_zstep.sv
// Horizontal zoom accumulator: yields the source column for each output pixel
// and flags the step that carries the integer part past the end of the tile.
module jt053247_zstep #(
    parameter int ZFRAC = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       keep,
    input  logic       step,
    input  logic [9:0] hzoom,
    output logic [3:0] src,
    output logic       done
);
    localparam int AW = 4 + ZFRAC + 1;

    logic [AW-1:0] acc_reg;
    logic [AW-1:0] acc_next;

    // The accumulator never exceeds 16.0 + hzoom, so the top bit is the
    // "integer part >= 16" flag.
    assign acc_next = acc_reg + AW'(hzoom);
    assign src      = acc_reg[ZFRAC+3:ZFRAC];
    assign done     = acc_next[AW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (start) begin
            acc_reg <= keep ? {{(AW-ZFRAC){1'b0}}, acc_reg[ZFRAC-1:0]} : '0;
        end else if (step) begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/jt053247_draw.sv
// Sprite tile drawer: fetches a 16-pixel row, applies flips and horizontal zoom,
// writes opaque pixels to the line buffer. JT053247_DRAW_CLIP_EN masks edge columns.
module jt053247_draw
    import jt053247_pkg::*;
#(
    parameter int ZFRAC = 6,
    parameter int MAXPX = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dr_start,
    output logic        dr_busy,
    input  logic [15:0] code,
    input  logic [9:0]  attr,
    input  logic        hflip,
    input  logic        vflip,
    input  logic [8:0]  hpos,
    input  logic [3:0]  ysub,
    input  logic [11:0] hzoom,
    input  logic        hz_keep,
    output logic [20:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    output logic        buf_we,
    output logic [8:0]  buf_addr,
    output logic [13:0] buf_din
);
    localparam int CW = $clog2(MAXPX);

    logic [1:0]  state_reg;
    tile_t       tile_reg;
    logic [63:0] row_reg;
    logic [CW-1:0] cnt_reg;
    logic        busy_reg;
    logic        rom_cs_reg;
    logic [20:0] rom_addr_reg;
    logic        buf_we_reg;
    logic [8:0]  buf_addr_reg;
    logic [13:0] buf_din_reg;

    logic [3:0]  pix_arr [16];
    logic [3:0]  src;
    logic [3:0]  col;
    logic [3:0]  pix;
    logic        zdone;
    logic        zstart;
    logic        zstep;
    logic        last_px;
    logic [8:0]  px_addr;
    logic        px_vis;
    logic        unused_hzoom;

    assign unused_hzoom = ^hzoom[11:10];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pix
            assign pix_arr[gi] = row_reg[4*gi+3:4*gi];
        end
    endgenerate

    assign zstart = (state_reg == ST_FETCH1) && rom_ok && (tile_reg.hzoom != '0);
    assign zstep  = (state_reg == ST_DRAW);

    jt053247_zstep #(.ZFRAC(ZFRAC)) u_zstep (
        .clk   (clk),
        .rst   (rst),
        .start (zstart),
        .keep  (tile_reg.keep),
        .step  (zstep),
        .hzoom (tile_reg.hzoom),
        .src   (src),
        .done  (zdone)
    );

    assign col     = src ^ {4{tile_reg.hflip}};
    assign pix     = pix_arr[col];
    assign px_addr = tile_reg.hpos + 9'(cnt_reg);
    assign last_px = zdone || (cnt_reg == CW'(MAXPX - 1));

`ifdef JT053247_DRAW_CLIP_EN
    assign px_vis = (px_addr >= CLIP_LO) && (px_addr <= CLIP_HI);
`else
    assign px_vis = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            tile_reg     <= '0;
            row_reg      <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            rom_cs_reg   <= 1'b0;
            rom_addr_reg <= '0;
            buf_we_reg   <= 1'b0;
            buf_addr_reg <= '0;
            buf_din_reg  <= '0;
        end else begin
            buf_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (dr_start) begin
                        tile_reg     <= '{attr: attr, hflip: hflip, hpos: hpos,
                                          hzoom: hzoom[9:0], keep: hz_keep};
                        busy_reg     <= 1'b1;
                        rom_cs_reg   <= 1'b1;
                        rom_addr_reg <= {code, ysub ^ {4{vflip}}, 1'b0};
                        state_reg    <= ST_FETCH0;
                    end
                end
                ST_FETCH0: begin
                    if (rom_ok) begin
                        row_reg[31:0]   <= rom_data;
                        rom_addr_reg[0] <= 1'b1;
                        state_reg       <= ST_FETCH1;
                    end
                end
                ST_FETCH1: begin
                    if (rom_ok) begin
                        row_reg[63:32] <= rom_data;
                        rom_cs_reg     <= 1'b0;
                        cnt_reg        <= '0;
                        // A zero zoom would never advance; treat it as an empty tile.
                        if (tile_reg.hzoom == '0) begin
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_DRAW;
                        end
                    end
                end
                ST_DRAW: begin
                    buf_we_reg   <= (pix != TRANSP) && px_vis;
                    buf_addr_reg <= px_addr;
                    buf_din_reg  <= {tile_reg.attr, pix};
                    cnt_reg      <= cnt_reg + 1'b1;
                    if (last_px) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign dr_busy  = busy_reg;
    assign rom_cs   = rom_cs_reg;
    assign rom_addr = rom_addr_reg;
    assign buf_we   = buf_we_reg;
    assign buf_addr = buf_addr_reg;
    assign buf_din  = buf_din_reg;

endmodule
